// File: rtl/tron_dir_ctrl.sv
// Tron player input conditioner: synchronizes and debounces both players' direction buttons
// and the start button, then commits one pending turn per player on each movement tick.
module tron_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] p1_btn,
  input  logic [3:0] p2_btn,
  input  logic       BtnC,
  input  logic       tick,
  input  logic       init,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       start_pulse,
  output logic [3:0] p1_btn_db,
  output logic [3:0] p2_btn_db
);

  localparam int               N_IN     = 9;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button bit index equals the direction code, so a press bit maps straight onto a direction.
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  logic [N_IN-1:0]  w_raw;
  logic [N_IN-1:0]  r_sync1;
  logic [N_IN-1:0]  r_sync2;
  logic [N_IN-1:0]  r_stable;
  logic [N_IN-1:0]  r_stable_d;
  logic [CNT_W-1:0] r_cnt [N_IN];
  logic [N_IN-1:0]  w_press;

  dir_e             r_dir      [2];
  dir_e             r_pend_dir [2];
  logic [1:0]       r_pend_v;
  logic             r_start_pulse;

  dir_e             w_sel [2];
  logic [1:0]       w_any;

  assign w_raw = {BtnC, p2_btn, p1_btn};

  // NOTE: every sequential block uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < N_IN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  // NOTE: outputs of a combinational block get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_sel[p] = DIR_LEFT;
      if      (w_press[4*p+0]) w_sel[p] = DIR_UP;
      else if (w_press[4*p+1]) w_sel[p] = DIR_RIGHT;
      else if (w_press[4*p+3]) w_sel[p] = DIR_DOWN;
      w_any[p] = |w_press[4*p +: 4];
    end
  end

  // NOTE: r_pend_dir has no reset; it is only consumed while r_pend_v is set.
  always_ff @(posedge Clk) begin
    if (Reset || init) begin
      r_dir[0] <= DIR_UP;
      r_dir[1] <= DIR_DOWN;
      r_pend_v <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (tick) begin
          if (r_pend_v[p] && (r_pend_dir[p] != ~r_dir[p])) r_dir[p] <= r_pend_dir[p];
          r_pend_v[p] <= 1'b0;
        end
        // Placed after the tick clause so a coincident press survives as the next pending turn.
        if (w_any[p]) begin
          r_pend_dir[p] <= w_sel[p];
          r_pend_v[p]   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_start_pulse <= 1'b0;
    else       r_start_pulse <= w_press[8];
  end

  assign p1_dir      = r_dir[0];
  assign p2_dir      = r_dir[1];
  assign start_pulse = r_start_pulse;
  assign p1_btn_db   = r_stable[3:0];
  assign p2_btn_db   = r_stable[7:4];

endmodule
